// File: rtl/spi_ram_pkg.sv
// Shared opcode, state and requester definitions for the SPI/host RAM arbiter.
package spi_ram_pkg;

   typedef logic [1:0] opcode_t;
   typedef logic [1:0] state_t;

   localparam opcode_t OP_SET_WADDR = 2'b00;
   localparam opcode_t OP_WRITE     = 2'b01;
   localparam opcode_t OP_SET_RADDR = 2'b10;
   localparam opcode_t OP_READ      = 2'b11;

   localparam state_t ST_IDLE     = 2'd0;
   localparam state_t ST_WRITE    = 2'd1;
   localparam state_t ST_RD_ISSUE = 2'd2;
   localparam state_t ST_RD_WAIT  = 2'd3;

   localparam int unsigned REQ_SPI  = 0;
   localparam int unsigned REQ_HOST = 1;

endpackage

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; remembers who was granted last so ties alternate.
module rr_arb2
   import spi_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_host_q;
   logic last_host_d;

   always_comb begin
      gnt         = '0;
      last_host_d = last_host_q;
      if (en) begin
         if (req[REQ_SPI] && req[REQ_HOST]) begin
            gnt[REQ_SPI]  = last_host_q;
            gnt[REQ_HOST] = ~last_host_q;
         end else begin
            gnt = req;
         end
         if (gnt != '0) begin
            last_host_d = gnt[REQ_HOST];
         end
      end
   end

   // Reset to "host last" so the first tie goes to SPI.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_host_q <= 1'b1;
      end else begin
         last_host_q <= last_host_d;
      end
   end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares a single-port RAM between an SPI command stream and a local host port.
module spi_ram_arbiter
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W+1:0] spi_rx_data,
   input  logic              spi_rx_valid,
   output logic [DATA_W-1:0] spi_tx_data,
   output logic              spi_tx_valid,
   output logic              spi_overrun,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t            state_q,        state_d;
   logic              rx_valid_q;
   logic [ADDR_W-1:0] spi_wr_addr_q,  spi_wr_addr_d;
   logic [ADDR_W-1:0] spi_rd_addr_q,  spi_rd_addr_d;
   logic              pend_q,         pend_d;
   logic              pend_we_q,      pend_we_d;
   logic [ADDR_W-1:0] pend_addr_q,    pend_addr_d;
   logic [DATA_W-1:0] pend_data_q,    pend_data_d;
   logic              gnt_host_q,     gnt_host_d;
   logic [ADDR_W-1:0] acc_addr_q,     acc_addr_d;
   logic [DATA_W-1:0] acc_wdata_q,    acc_wdata_d;
   logic [DATA_W-1:0] spi_tx_data_q,  spi_tx_data_d;
   logic              spi_tx_valid_q, spi_tx_valid_d;
   logic              overrun_q,      overrun_d;
   logic [DATA_W-1:0] host_rdata_q,   host_rdata_d;
   logic              host_rd_ack_q,  host_rd_ack_d;

   logic              rx_edge;
   opcode_t           opcode;
   logic [DATA_W-1:0] payload;
   logic [1:0]        arb_req;
   logic [1:0]        arb_gnt;
   logic              pend_clr;

   assign opcode  = spi_rx_data[DATA_W+1:DATA_W];
   assign payload = spi_rx_data[DATA_W-1:0];
   assign rx_edge = spi_rx_valid & ~rx_valid_q;

   assign host_ack = host_rd_ack_q | ((state_q == ST_WRITE) & gnt_host_q);

   // Host is masked during its own ack cycle so a still-high req is not re-granted.
   always_comb begin
      arb_req           = '0;
      arb_req[REQ_SPI]  = pend_q;
      arb_req[REQ_HOST] = host_req & ~host_ack;
   end

   rr_arb2 u_rr_arb2 (
      .clk (clk),
      .rst (rst),
      .en  (state_q == ST_IDLE),
      .req (arb_req),
      .gnt (arb_gnt)
   );

   always_comb begin
      state_d        = state_q;
      gnt_host_d     = gnt_host_q;
      acc_addr_d     = acc_addr_q;
      acc_wdata_d    = acc_wdata_q;
      spi_tx_data_d  = spi_tx_data_q;
      spi_tx_valid_d = 1'b0;
      host_rdata_d   = host_rdata_q;
      host_rd_ack_d  = 1'b0;
      pend_clr       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (arb_gnt[REQ_SPI]) begin
               gnt_host_d  = 1'b0;
               acc_addr_d  = pend_addr_q;
               acc_wdata_d = pend_data_q;
               state_d     = pend_we_q ? ST_WRITE : ST_RD_ISSUE;
               pend_clr    = 1'b1;
            end else if (arb_gnt[REQ_HOST]) begin
               gnt_host_d  = 1'b1;
               acc_addr_d  = host_addr;
               acc_wdata_d = host_wdata;
               state_d     = host_we ? ST_WRITE : ST_RD_ISSUE;
            end
         end
         ST_WRITE:    state_d = ST_IDLE;
         ST_RD_ISSUE: state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (gnt_host_q) begin
               host_rdata_d  = ram_rdata;
               host_rd_ack_d = 1'b1;
            end else begin
               spi_tx_data_d  = ram_rdata;
               spi_tx_valid_d = 1'b1;
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The slot freed by this cycle's grant may be refilled by a same-cycle edge.
   always_comb begin
      spi_wr_addr_d = spi_wr_addr_q;
      spi_rd_addr_d = spi_rd_addr_q;
      pend_d        = pend_q & ~pend_clr;
      pend_we_d     = pend_we_q;
      pend_addr_d   = pend_addr_q;
      pend_data_d   = pend_data_q;
      overrun_d     = overrun_q;

      if (rx_edge) begin
         case (opcode)
            OP_SET_WADDR: spi_wr_addr_d = ADDR_W'(payload);
            OP_SET_RADDR: spi_rd_addr_d = ADDR_W'(payload);
            OP_WRITE: begin
               if (pend_d) begin
                  overrun_d = 1'b1;
               end else begin
                  pend_d      = 1'b1;
                  pend_we_d   = 1'b1;
                  pend_addr_d = spi_wr_addr_q;
                  pend_data_d = payload;
               end
            end
            OP_READ: begin
               if (pend_d) begin
                  overrun_d = 1'b1;
               end else begin
                  pend_d      = 1'b1;
                  pend_we_d   = 1'b0;
                  pend_addr_d = spi_rd_addr_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rx_valid_q     <= 1'b0;
         spi_wr_addr_q  <= '0;
         spi_rd_addr_q  <= '0;
         pend_q         <= 1'b0;
         pend_we_q      <= 1'b0;
         pend_addr_q    <= '0;
         pend_data_q    <= '0;
         gnt_host_q     <= 1'b0;
         acc_addr_q     <= '0;
         acc_wdata_q    <= '0;
         spi_tx_data_q  <= '0;
         spi_tx_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         host_rdata_q   <= '0;
         host_rd_ack_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         rx_valid_q     <= spi_rx_valid;
         spi_wr_addr_q  <= spi_wr_addr_d;
         spi_rd_addr_q  <= spi_rd_addr_d;
         pend_q         <= pend_d;
         pend_we_q      <= pend_we_d;
         pend_addr_q    <= pend_addr_d;
         pend_data_q    <= pend_data_d;
         gnt_host_q     <= gnt_host_d;
         acc_addr_q     <= acc_addr_d;
         acc_wdata_q    <= acc_wdata_d;
         spi_tx_data_q  <= spi_tx_data_d;
         spi_tx_valid_q <= spi_tx_valid_d;
         overrun_q      <= overrun_d;
         host_rdata_q   <= host_rdata_d;
         host_rd_ack_q  <= host_rd_ack_d;
      end
   end

   assign spi_tx_data  = spi_tx_data_q;
   assign spi_tx_valid = spi_tx_valid_q;
   assign spi_overrun  = overrun_q;
   assign host_rdata   = host_rdata_q;
   assign ram_en       = (state_q == ST_WRITE) | (state_q == ST_RD_ISSUE);
   assign ram_we       = (state_q == ST_WRITE);
   assign ram_addr     = acc_addr_q;
   assign ram_wdata    = acc_wdata_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter with a behavioural single-port RAM.
module tb_spi_ram_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] spi_rx_data = '0;
   logic       spi_rx_valid = 1'b0;
   logic [7:0] spi_tx_data;
   logic       spi_tx_valid;
   logic       spi_overrun;
   logic       host_req = 1'b0;
   logic       host_we = 1'b0;
   logic [7:0] host_addr = '0;
   logic [7:0] host_wdata = '0;
   logic       host_ack;
   logic [7:0] host_rdata;
   logic       ram_en, ram_we;
   logic [7:0] ram_addr, ram_wdata;
   logic [7:0] ram_rdata = '0;

   int checks = 0;
   int errors = 0;

   spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk(clk), .rst(rst),
      .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
      .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid), .spi_overrun(spi_overrun),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_ack(host_ack), .host_rdata(host_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:255];
   initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
      if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
   end

   logic [7:0] wr_addr_log [0:255];
   logic [7:0] wr_data_log [0:255];
   logic [7:0] rd_addr_log [0:255];
   int wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, ack_cnt = 0;
   logic [7:0] last_tx = '0;

   always @(negedge clk) begin
      if (!rst) begin
         if (ram_en && ram_we) begin
            wr_addr_log[wr_cnt % 256] = ram_addr;
            wr_data_log[wr_cnt % 256] = ram_wdata;
            wr_cnt++;
         end
         if (ram_en && !ram_we) begin
            rd_addr_log[rd_cnt % 256] = ram_addr;
            rd_cnt++;
         end
         if (spi_tx_valid) begin
            tx_cnt++;
            last_tx = spi_tx_data;
         end
         if (host_ack) ack_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      spi_rx_valid = 1'b0;
      host_req = 1'b0;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic drive_rx(input logic [1:0] op, input logic [7:0] pl, input int hold, input int low);
      spi_rx_data = {op, pl};
      spi_rx_valid = 1'b1;
      tick(hold);
      spi_rx_valid = 1'b0;
      tick(low);
   endtask

   task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] wd,
                              output logic [7:0] rd);
      int w;
      host_we = we;
      host_addr = a;
      host_wdata = wd;
      host_req = 1'b1;
      w = 0;
      @(negedge clk);
      while (!host_ack && w < 40) begin
         @(negedge clk);
         w++;
      end
      check("host_ack_timeout", 32'(host_ack), 32'd1);
      rd = host_rdata;
      @(posedge clk);
      #1;
      host_req = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx_valid"}, 32'(spi_tx_valid), 32'd0);
      check({tag, "_tx_data"}, 32'(spi_tx_data), 32'd0);
      check({tag, "_overrun"}, 32'(spi_overrun), 32'd0);
      check({tag, "_host_ack"}, 32'(host_ack), 32'd0);
      check({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
      check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
      check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
   endtask

   typedef struct {
      logic [1:0] op;
      logic [7:0] pl;
      int         n_wr;
      int         n_rd;
      logic [7:0] e_addr;
      logic [7:0] e_data;
   } vec_t;

   vec_t vt [0:16];

   initial begin
      int k, found, b0, t0, a0, w0;
      logic [7:0] rd;

      vt[0]  = '{2'b00, 8'h12, 0, 0, 8'h00, 8'h00};
      vt[1]  = '{2'b01, 8'hAB, 1, 0, 8'h12, 8'hAB};
      vt[2]  = '{2'b00, 8'h34, 0, 0, 8'h00, 8'h00};
      vt[3]  = '{2'b01, 8'hCD, 1, 0, 8'h34, 8'hCD};
      vt[4]  = '{2'b01, 8'hEF, 1, 0, 8'h34, 8'hEF};
      vt[5]  = '{2'b10, 8'h12, 0, 0, 8'h00, 8'h00};
      vt[6]  = '{2'b11, 8'h00, 0, 1, 8'h00, 8'hAB};
      vt[7]  = '{2'b10, 8'h34, 0, 0, 8'h00, 8'h00};
      vt[8]  = '{2'b11, 8'hFF, 0, 1, 8'h00, 8'hEF};
      vt[9]  = '{2'b00, 8'h00, 0, 0, 8'h00, 8'h00};
      vt[10] = '{2'b01, 8'h55, 1, 0, 8'h00, 8'h55};
      vt[11] = '{2'b00, 8'hFF, 0, 0, 8'h00, 8'h00};
      vt[12] = '{2'b01, 8'hAA, 1, 0, 8'hFF, 8'hAA};
      vt[13] = '{2'b10, 8'hFF, 0, 0, 8'h00, 8'h00};
      vt[14] = '{2'b11, 8'h00, 0, 1, 8'h00, 8'hAA};
      vt[15] = '{2'b10, 8'h00, 0, 0, 8'h00, 8'h00};
      vt[16] = '{2'b11, 8'h00, 0, 1, 8'h00, 8'h55};

      tick(1);
      do_reset();
      check_reset_outputs("reset");

      // Write latency with a held-high rx_valid level (one word only).
      drive_rx(2'b00, 8'h12, 2, 1);
      w0 = wr_cnt;
      spi_rx_data = {2'b01, 8'hAB};
      spi_rx_valid = 1'b1;
      found = 0;
      for (k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (found == 0 && ram_en && ram_we) begin
            found = k;
            check("wr_lat_addr", 32'(ram_addr), 32'h12);
            check("wr_lat_data", 32'(ram_wdata), 32'hAB);
         end
      end
      check("wr_latency", 32'(found), 32'd2);
      check("held_level_one_write", 32'(wr_cnt - w0), 32'd1);
      @(posedge clk); #1;
      spi_rx_valid = 1'b0;
      tick(1);

      // Read latency: data pulse 3 cycles after the edge is registered.
      drive_rx(2'b10, 8'h12, 2, 1);
      t0 = tx_cnt;
      spi_rx_data = {2'b11, 8'h00};
      spi_rx_valid = 1'b1;
      found = 0;
      for (k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (found == 0 && spi_tx_valid) begin
            found = k;
            check("rd_lat_data", 32'(spi_tx_data), 32'hAB);
         end
      end
      check("rd_latency", 32'(found), 32'd4);
      check("rd_single_pulse", 32'(tx_cnt - t0), 32'd1);
      @(posedge clk); #1;
      spi_rx_valid = 1'b0;
      tick(1);

      for (int i = 0; i < 17; i++) begin
         w0 = wr_cnt;
         t0 = tx_cnt;
         drive_rx(vt[i].op, vt[i].pl, 2, 1);
         tick(6);
         check($sformatf("vec%0d_writes", i), 32'(wr_cnt - w0), 32'(vt[i].n_wr));
         check($sformatf("vec%0d_reads", i), 32'(tx_cnt - t0), 32'(vt[i].n_rd));
         if (vt[i].n_wr == 1) begin
            check($sformatf("vec%0d_waddr", i), 32'(wr_addr_log[(wr_cnt - 1) % 256]), 32'(vt[i].e_addr));
            check($sformatf("vec%0d_wdata", i), 32'(wr_data_log[(wr_cnt - 1) % 256]), 32'(vt[i].e_data));
         end
         if (vt[i].n_rd == 1) check($sformatf("vec%0d_rdata", i), 32'(last_tx), 32'(vt[i].e_data));
         check($sformatf("vec%0d_overrun", i), 32'(spi_overrun), 32'd0);
      end

      // First tie after reset goes to SPI, host follows with a single ack.
      do_reset();
      drive_rx(2'b00, 8'h20, 1, 1);
      w0 = wr_cnt;
      a0 = ack_cnt;
      fork
         drive_rx(2'b01, 8'h77, 1, 1);
         begin
            tick(1);
            host_access(1'b1, 8'h05, 8'h5A, rd);
         end
      join
      tick(4);
      check("tie_count", 32'(wr_cnt - w0), 32'd2);
      check("tie_first_addr", 32'(wr_addr_log[w0 % 256]), 32'h20);
      check("tie_first_data", 32'(wr_data_log[w0 % 256]), 32'h77);
      check("tie_second_addr", 32'(wr_addr_log[(w0 + 1) % 256]), 32'h05);
      check("tie_second_data", 32'(wr_data_log[(w0 + 1) % 256]), 32'h5A);
      check("tie_host_acks", 32'(ack_cnt - a0), 32'd1);

      // Continuous host reads against paced SPI reads alternate.
      drive_rx(2'b10, 8'h20, 1, 1);
      b0 = rd_cnt;
      fork
         for (int h = 0; h < 4; h++) begin
            host_access(1'b0, 8'h05, 8'h00, rd);
            check($sformatf("rr_host_rdata%0d", h), 32'(rd), 32'h5A);
         end
         for (int s = 0; s < 4; s++) begin
            int w;
            drive_rx(2'b11, 8'h00, 1, 1);
            w = 0;
            while (!spi_tx_valid && w < 40) begin
               @(negedge clk);
               w++;
            end
            check($sformatf("rr_spi_valid%0d", s), 32'(spi_tx_valid), 32'd1);
            check($sformatf("rr_spi_rdata%0d", s), 32'(spi_tx_data), 32'h77);
            @(posedge clk); #1;
         end
      join
      tick(4);
      check("rr_read_count", 32'(rd_cnt - b0), 32'd8);
      for (int i = 0; i < 8; i++)
         check($sformatf("rr_order%0d", i), 32'(rd_addr_log[(b0 + i) % 256]),
               (i % 2 == 0) ? 32'h05 : 32'h20);
      check("rr_overrun", 32'(spi_overrun), 32'd0);

      // Edge landing in the cycle its slot is granted is accepted.
      drive_rx(2'b00, 8'h40, 1, 1);
      w0 = wr_cnt;
      fork
         host_access(1'b0, 8'h05, 8'h00, rd);
         begin
            drive_rx(2'b01, 8'h11, 1, 2);
            drive_rx(2'b01, 8'h22, 1, 1);
         end
      join
      tick(6);
      check("slot_reuse_overrun", 32'(spi_overrun), 32'd0);
      check("slot_reuse_count", 32'(wr_cnt - w0), 32'd2);
      check("slot_reuse_data0", 32'(wr_data_log[w0 % 256]), 32'h11);
      check("slot_reuse_data1", 32'(wr_data_log[(w0 + 1) % 256]), 32'h22);

      // Second posted write while host holds the RAM is dropped; flag is sticky.
      w0 = wr_cnt;
      fork
         host_access(1'b0, 8'h05, 8'h00, rd);
         begin
            drive_rx(2'b01, 8'h33, 1, 1);
            drive_rx(2'b01, 8'h44, 1, 1);
         end
      join
      tick(6);
      check("ovr_flag", 32'(spi_overrun), 32'd1);
      check("ovr_count", 32'(wr_cnt - w0), 32'd1);
      check("ovr_kept_data", 32'(wr_data_log[w0 % 256]), 32'h33);
      drive_rx(2'b01, 8'h66, 1, 1);
      tick(6);
      check("ovr_sticky", 32'(spi_overrun), 32'd1);
      check("ovr_after_write", 32'(wr_data_log[(wr_cnt - 1) % 256]), 32'h66);
      do_reset();
      check("ovr_cleared", 32'(spi_overrun), 32'd0);

      // Reset during RD_ISSUE aborts the read.
      drive_rx(2'b10, 8'h12, 1, 1);
      t0 = tx_cnt;
      spi_rx_data = {2'b11, 8'h00};
      spi_rx_valid = 1'b1;
      tick(2);
      check("abort_in_rd_issue", 32'({ram_en, ram_we}), 32'b10);
      rst = 1'b1;
      spi_rx_valid = 1'b0;
      tick(1);
      rst = 1'b0;
      check_reset_outputs("abort");
      tick(6);
      check("abort_no_tx", 32'(tx_cnt - t0), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

endmodule

// File: doc/spi_ram_arbiter.md
SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8: RAM data width; spi_rx_data width is DATA_W+2.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port spi_rx_data, input, DATA_W+2: SPI slave word; [9:8] opcode, [7:0] payload.
REQ-006 SHALL have port spi_rx_valid, input, 1: SPI slave word valid (level; held until frame ends).
REQ-007 SHALL have port spi_tx_data, output, DATA_W: read data returned to SPI slave.
REQ-008 SHALL have port spi_tx_valid, output, 1: spi_tx_data valid, one-cycle pulse.
REQ-009 SHALL have port spi_overrun, output, 1: sticky flag; SPI command dropped.
REQ-010 SHALL have port host_req, input, 1: local host access request; held until host_ack.
REQ-011 SHALL have port host_we, input, 1: host write (1) or read (0).
REQ-012 SHALL have port host_addr, input, ADDR_W: host address.
REQ-013 SHALL have port host_wdata, input, DATA_W: host write data.
REQ-014 SHALL have port host_ack, output, 1: one-cycle completion pulse.
REQ-015 SHALL have port host_rdata, output, DATA_W: host read data, valid with host_ack on reads.
REQ-016 SHALL have ports ram_en, ram_we (output, 1), ram_addr (output, ADDR_W), ram_wdata (output, DATA_W): single-port RAM command.
REQ-017 SHALL have port ram_rdata, input, DATA_W: RAM read data, valid the cycle after ram_en && !ram_we.

Function
REQ-018 SHALL accept an SPI word only on a rising edge of spi_rx_valid (previous-cycle register); a held-high level is one word.
REQ-019 SHALL decode opcode 00: latch payload into spi_wr_addr; no RAM access.
REQ-020 SHALL decode opcode 01: post a pending RAM write of payload to spi_wr_addr.
REQ-021 SHALL decode opcode 10: latch payload into spi_rd_addr; no RAM access.
REQ-022 SHALL decode opcode 11: post a pending RAM read of spi_rd_addr; payload ignored.
REQ-023 SHALL hold at most one pending SPI access; a posted access arriving while one is pending SHALL be dropped and SHALL set spi_overrun.
REQ-024 SHALL use FSM states IDLE, WRITE, RD_ISSUE, RD_WAIT.
REQ-025 IDLE: if only one requester is pending, grant it; if both, grant the requester not granted last (round-robin); on first contention after reset, SPI wins.
REQ-026 WRITE (1 cycle): ram_en=1, ram_we=1, address/data of the grantee; host grantee gets host_ack the same cycle; next state IDLE.
REQ-027 RD_ISSUE (1 cycle): ram_en=1, ram_we=0, grantee's address; next state RD_WAIT.
REQ-028 RD_WAIT (1 cycle): capture ram_rdata into spi_tx_data with spi_tx_valid=1, or into host_rdata with host_ack=1; next state IDLE.
REQ-029 Grant decision SHALL register in IDLE; a request becomes a RAM access the cycle after IDLE sees it (write latency 1 cycle; read data returned 3 cycles after IDLE grant decision).
REQ-030 ram_en SHALL be 0 in IDLE and RD_WAIT; ram_addr/ram_wdata don't-care when ram_en=0.
REQ-031 An SPI edge arriving in the same cycle its pending slot is cleared by grant SHALL be accepted, not counted as overrun.
REQ-032 host_req deasserted before host_ack is a protocol violation; behaviour unspecified.

Reset
REQ-033 On rst: state IDLE, pending slot empty, spi_wr_addr=spi_rd_addr=0, last-grant=HOST (so SPI wins first tie), spi_tx_data=0, spi_tx_valid=0, spi_overrun=0, host_ack=0, host_rdata=0, ram_en=0, ram_we=0, rx_valid edge register=0.
REQ-034 rst asserted mid-access SHALL abort it; no host_ack or spi_tx_valid SHALL issue for the aborted access.

Structure
REQ-035 Opcode constants (00/01/10/11) and state enum SHALL live in shared package spi_ram_pkg.
REQ-036 Round-robin decision SHALL be sub-module rr_arb2 (2 requests, grant one-hot, last-grant register).

Verification
REQ-037 SPI 00 0x12 then 01 0xAB -> one cycle ram_en=1, ram_we=1, ram_addr=0x12, ram_wdata=0xAB.
REQ-038 SPI 10 0x12 then 11, RAM holds 0xAB -> spi_tx_valid pulse, spi_tx_data=0xAB, 3 cycles after edge seen.
REQ-039 host_req write 0x05/0x5A concurrent with SPI write pending after reset -> SPI served first, host second; host_ack single pulse.
REQ-040 Continuous host_req reads plus repeated SPI reads -> grants alternate SPI/host; no starvation.
REQ-041 Two SPI 01 edges while host holds the RAM -> second dropped, spi_overrun=1 and stays 1 until rst.
REQ-042 rst asserted in RD_ISSUE -> next cycle state IDLE, all outputs at reset values, no spi_tx_valid.
